// File: rtl/card_dealer_if.sv
// Request/load bundle between a card requester, the dealer and the hand register.
// The master side issues deal/new-hand requests; the slave side (card_dealer)
// drives the hand-register load port and the status flags.
interface card_dealer_if;
  logic       deal;       // request one card
  logic       new_hand;   // request a hand clear
  logic [3:0] d;          // card code 0..12 for the hand register
  logic [1:0] pos;        // target slot for d
  logic       ld;         // one-cycle load strobe
  logic       hand_clr;   // one-cycle clear strobe
  logic [2:0] cards;      // cards loaded into the current hand, 0..4
  logic       hand_full;  // cards == 4
  logic       busy;       // dealer is not idle
  logic       deny;       // deal refused, hand already full

  modport master (
    output deal, new_hand,
    input  d, pos, ld, hand_clr, cards, hand_full, busy, deny
  );

  modport slave (
    input  deal, new_hand,
    output d, pos, ld, hand_clr, cards, hand_full, busy, deny
  );
endinterface

// File: rtl/card_dealer.sv
// Random card source for the blackjack datapath.
// Draws rank codes 0..12 from a free-running 16-bit Fibonacci LFSR with bounded
// rejection sampling, loads them into successive slots of the hand register,
// clears the hand on request and refuses deals once four cards are held.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  card_dealer_if.slave deal_bus
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int          TW   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_DRAW,
    S_LOAD
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_live;      // low only between reset release and the first edge
  logic [15:0]   r_lfsr;
  logic [TW-1:0] r_tries;
  logic [3:0]    r_d;
  logic [1:0]    r_pos;
  logic [2:0]    r_cards;
  logic          r_deny;
  logic          w_deny_next;

  logic          w_fb;
  logic [3:0]    w_sample;
  logic          w_accept;
  logic          w_last_try;
  logic          w_full;

  assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_sample   = r_lfsr[3:0];
  assign w_accept   = (w_sample < 4'd13);
  assign w_last_try = (r_tries >= LAST_TRY);
  assign w_full     = (r_cards == 3'd4);

  // Next-state decode and the deny request; inputs are looked at only in IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_deny_next  = 1'b0;
    case (r_state)
      // The reset state holds until the first edge after release so the clear
      // strobe lands in a full, visible cycle rather than inside reset.
      S_CLEAR: if (r_live) w_state_next = S_IDLE;
      S_IDLE: begin
        if (deal_bus.new_hand) begin
          w_state_next = S_CLEAR;
        end else if (deal_bus.deal) begin
          if (!w_full) w_state_next = S_DRAW;
          else         w_deny_next  = 1'b1;
        end
      end
      S_DRAW:  if (w_accept || w_last_try) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_IDLE;
      default: w_state_next = S_CLEAR;
    endcase
  end

  // State register, liveness flag and the registered deny pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state <= S_CLEAR;
      r_live  <= 1'b0;
      r_deny  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_live  <= 1'b1;
      r_deny  <= w_deny_next;
    end
  end

  // Free-running LFSR, frozen only while clearing the hand.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  r_lfsr <= SEED;
    else if (r_state != S_CLEAR) r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  // Try counter: restarted in IDLE, bumped on each rejected non-final sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                               r_tries <= '0;
    else if (r_state == S_IDLE)                              r_tries <= '0;
    else if (r_state == S_DRAW && !w_accept && !w_last_try)  r_tries <= r_tries + TW'(1);
  end

  // Card and slot are captured on the edge entering LOAD and held until the next load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_d   <= 4'd0;
      r_pos <= 2'd0;
    end else if (r_state == S_DRAW && w_state_next == S_LOAD) begin
      // On the final try an out-of-range sample folds down to 0..2.
      r_d   <= w_accept ? w_sample : (w_sample - 4'd13);
      r_pos <= r_cards[1:0];
    end
  end

  // Card count: zeroed by CLEAR, incremented at the end of LOAD, saturating at 4.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                              r_cards <= 3'd0;
    else if (r_state == S_CLEAR)            r_cards <= 3'd0;
    else if (r_state == S_LOAD && !w_full)  r_cards <= r_cards + 3'd1;
  end

  assign deal_bus.d         = r_d;
  assign deal_bus.pos       = r_pos;
  assign deal_bus.ld        = (r_state == S_LOAD);
  assign deal_bus.hand_clr  = (r_state == S_CLEAR) && r_live;
  assign deal_bus.busy      = (r_state != S_IDLE) && r_live;
  assign deal_bus.deny      = r_deny;
  assign deal_bus.cards     = r_cards;
  assign deal_bus.hand_full = w_full;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer. Three instances with different seeds share
// clock and reset; each scenario drives only the instance it is about.
// Outputs are sampled 1 time unit after the rising edge, inputs driven there too.
module tb_card_dealer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  card_dealer_if if_a ();
  card_dealer_if if_b ();
  card_dealer_if if_c ();

  // Seed 5: first draw 0xA accepted immediately.
  card_dealer #(.LFSR_SEED(16'h0005)) u_a (.i_clk(clk), .i_rst(rst), .deal_bus(if_a.slave));
  // Seed F: first sample 14 rejected, second sample 12 accepted.
  card_dealer #(.LFSR_SEED(16'h000F)) u_b (.i_clk(clk), .i_rst(rst), .deal_bus(if_b.slave));
  // Seed C107 with three tries: samples F, F, F, so the fallback gives 15-13 = 2.
  card_dealer #(.LFSR_SEED(16'hC107), .MAX_TRIES(3)) u_c (.i_clk(clk), .i_rst(rst), .deal_bus(if_c.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse; returns right after release, before the clear cycle.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_ld;
    logic found;

    if_a.deal = 1'b0; if_a.new_hand = 1'b0;
    if_b.deal = 1'b0; if_b.new_hand = 1'b0;
    if_c.deal = 1'b0; if_c.new_hand = 1'b0;

    // ---- Reset values and wake-up sequence (u_a) ----
    repeat (3) tick();
    check("rst_ld",       if_a.ld,       0);
    check("rst_hand_clr", if_a.hand_clr, 0);
    check("rst_busy",     if_a.busy,     0);
    check("rst_deny",     if_a.deny,     0);
    check("rst_cards",    if_a.cards,    0);
    check("rst_d",        if_a.d,        0);
    check("rst_pos",      if_a.pos,      0);
    rst = 1'b0;
    tick();
    check("wake_hand_clr", if_a.hand_clr, 1);
    check("wake_busy",     if_a.busy,     1);
    tick();
    check("idle_hand_clr", if_a.hand_clr, 0);
    check("idle_busy",     if_a.busy,     0);
    check("idle_ld",       if_a.ld,       0);
    check("idle_cards",    if_a.cards,    0);

    // ---- Accepted draw: LD in n+2 with D=A ----
    if_a.deal = 1'b1;
    tick();
    if_a.deal = 1'b0;
    check("acc_draw_ld",   if_a.ld,   0);
    check("acc_draw_busy", if_a.busy, 1);
    tick();
    check("acc_ld",  if_a.ld,  1);
    check("acc_d",   if_a.d,   4'hA);
    check("acc_pos", if_a.pos, 0);
    tick();
    check("acc_after_ld",    if_a.ld,    0);
    check("acc_after_cards", if_a.cards, 1);
    check("acc_d_held",      if_a.d,     4'hA);

    // ---- Fill the hand: slots 1..3 ----
    for (int k = 1; k < 4; k++) begin
      if_a.deal = 1'b1;
      tick();
      if_a.deal = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if (if_a.ld) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      check($sformatf("fill%0d_ld_seen", k), found, 1);
      check($sformatf("fill%0d_pos", k), if_a.pos, k);
      check($sformatf("fill%0d_d_range", k), (if_a.d < 4'd13), 1);
      tick();
    end
    check("full_cards", if_a.cards,     4);
    check("full_flag",  if_a.hand_full, 1);

    // ---- Fifth deal is denied ----
    if_a.deal = 1'b1;
    tick();
    if_a.deal = 1'b0;
    check("deny_pulse", if_a.deny, 1);
    check("deny_busy",  if_a.busy, 0);
    n_ld = int'(if_a.ld);
    tick();
    check("deny_one_cycle", if_a.deny, 0);
    repeat (10) begin
      n_ld += int'(if_a.ld);
      tick();
    end
    check("deny_no_ld",    n_ld,       0);
    check("deny_cards",    if_a.cards, 4);

    // ---- NEW_HAND wins over DEAL ----
    if_a.deal = 1'b1;
    if_a.new_hand = 1'b1;
    tick();
    if_a.deal = 1'b0;
    if_a.new_hand = 1'b0;
    check("prio_hand_clr", if_a.hand_clr, 1);
    check("prio_ld",       if_a.ld,       0);
    check("prio_deny",     if_a.deny,     0);
    tick();
    check("prio_clr_done", if_a.hand_clr,  0);
    check("prio_cards",    if_a.cards,     0);
    check("prio_not_full", if_a.hand_full, 0);
    check("prio_idle",     if_a.busy,      0);

    // ---- DEAL while busy is ignored ----
    if_a.deal = 1'b1;
    tick();
    check("busy_in_draw", if_a.busy, 1);
    tick();                     // deal still high on this edge, state was DRAW
    if_a.deal = 1'b0;
    n_ld = int'(if_a.ld);
    repeat (20) begin
      tick();
      n_ld += int'(if_a.ld);
    end
    check("busy_single_ld", n_ld,       1);
    check("busy_cards",     if_a.cards, 1);

    // ---- Rejection (u_b): 14 rejected, 12 accepted, LD in n+3 ----
    do_reset();
    tick();
    check("rej_wake_clr", if_b.hand_clr, 1);
    tick();
    if_b.deal = 1'b1;
    tick();
    if_b.deal = 1'b0;
    check("rej_try0_ld", if_b.ld, 0);
    tick();
    check("rej_try1_ld",   if_b.ld,   0);
    check("rej_try1_busy", if_b.busy, 1);
    tick();
    check("rej_ld",  if_b.ld,  1);
    check("rej_d",   if_b.d,   4'hC);
    check("rej_pos", if_b.pos, 0);
    tick();
    check("rej_cards", if_b.cards, 1);

    // ---- Reset in the middle of a draw (u_b) ----
    if_b.deal = 1'b1;
    tick();
    if_b.deal = 1'b0;
    check("mid_in_draw", if_b.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ld",    if_b.ld,    0);
    check("mid_rst_busy",  if_b.busy,  0);
    check("mid_rst_cards", if_b.cards, 0);
    n_ld = 0;
    repeat (2) begin
      tick();
      n_ld += int'(if_b.ld);
    end
    rst = 1'b0;
    tick();
    n_ld += int'(if_b.ld);
    check("mid_hand_clr", if_b.hand_clr, 1);
    tick();
    n_ld += int'(if_b.ld);
    check("mid_no_ld",  n_ld,         0);
    check("mid_cards",  if_b.cards,   0);
    check("mid_idle",   if_b.busy,    0);

    // ---- Fallback (u_c, three tries): all samples F, D = 2 ----
    do_reset();
    tick();
    tick();
    if_c.deal = 1'b1;
    tick();
    if_c.deal = 1'b0;
    check("fb_try0_ld",   if_c.ld,   0);
    check("fb_try0_busy", if_c.busy, 1);
    tick();
    check("fb_try1_ld", if_c.ld, 0);
    tick();
    check("fb_try2_ld", if_c.ld, 0);
    tick();
    check("fb_ld",  if_c.ld,  1);
    check("fb_d",   if_c.d,   4'h2);
    check("fb_pos", if_c.pos, 0);
    tick();
    check("fb_cards", if_c.cards, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
